// File: rtl/pc_next_gen_pkg.sv
// Shared definitions for the PC sequencer: state encoding and fetch geometry.
package pc_next_gen_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int INSN_BYTES   = 4;

  typedef enum logic [2:0] {
    BOOT,
    RUN,
    BUBBLE,
    HALT,
    ERR
  } state_t;

endpackage

// File: rtl/pc_next_gen_if.sv
// Fetch-request, redirect and status bundle between the PC sequencer and the front end.
interface pc_next_gen_if
  import pc_next_gen_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) ();

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] req_pc4;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            halt;
  logic            misaligned;
  logic [31:0]     fetch_count;

  modport master (
    output req_valid, req_pc, req_pc4, misaligned, fetch_count,
    input  req_ready, stall, redirect_valid, redirect_pc, halt
  );

  modport slave (
    input  req_valid, req_pc, req_pc4, misaligned, fetch_count,
    output req_ready, stall, redirect_valid, redirect_pc, halt
  );

endinterface

// File: rtl/pc_next_gen.sv
// Next-PC generator: issues sequential fetch requests, honours redirects,
// halts and backpressure, and flags misaligned redirect targets.
module pc_next_gen
  import pc_next_gen_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic           clock,
  input  logic           reset,
  pc_next_gen_if.master  io
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc4;
  logic            mis_q, mis_d;
  logic [31:0]     count_q, count_d;
  logic            fire;

  assign pc4            = pc_q + XLEN'(INSN_BYTES);
  assign fire           = (state_q == RUN) & io.req_ready & ~io.stall;
  assign io.req_valid   = (state_q == RUN);
  assign io.req_pc      = pc_q;
  assign io.req_pc4     = pc4;
  assign io.misaligned  = mis_q;
  assign io.fetch_count = count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      mis_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
      count_q <= count_d;
    end
  end

  // A fire is counted even when a redirect in the same cycle overrides the PC.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mis_d   = mis_q;
    count_d = count_q;
    if (fire) count_d = count_q + 32'd1;

    if (state_q == BOOT) begin
      state_d = RUN;
    end else if (io.redirect_valid) begin
      pc_d = io.redirect_pc;
      if (io.redirect_pc[1:0] == 2'b00) begin
        state_d = BUBBLE;
        mis_d   = 1'b0;
      end else begin
        state_d = ERR;
        mis_d   = 1'b1;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (fire)    pc_d    = pc4;
          if (io.halt) state_d = HALT;
        end
        BUBBLE:  state_d = io.halt ? HALT : RUN;
        HALT:    if (!io.halt) state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_next_gen.sv
// Bench for pc_next_gen: directed sequences with a scoreboard of expected fired PCs.
module tb_pc_next_gen;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [31:0] exp_q[$];

  pc_next_gen_if #(.XLEN(32)) bus ();

  pc_next_gen #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .io    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  // Scoreboard consumer: every accepted request must match the next queued PC.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n && bus.req_valid && bus.req_ready && !bus.stall) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("fire_pc", bus.req_pc, e);
        check("fire_pc4", bus.req_pc4, e + 32'd4);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n              = 1'b0;
    bus.req_ready      = 1'b1;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.halt           = 1'b0;
    #2;
    check("rst_valid", 32'(bus.req_valid), 32'd0);
    check("rst_pc", bus.req_pc, 32'h0);
    check("rst_pc4", bus.req_pc4, 32'h4);
    check("rst_mis", 32'(bus.misaligned), 32'd0);
    check("rst_count", bus.fetch_count, 32'd0);

    // Release reset: BOOT for one cycle, then requests 0x0, 0x4.
    tick();
    rst_n = 1'b1;
    check("boot_valid", 32'(bus.req_valid), 32'd0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    tick();
    check("first_valid", 32'(bus.req_valid), 32'd1);
    check("first_pc", bus.req_pc, 32'h0);
    tick();
    check("pc_4", bus.req_pc, 32'h4);
    tick();
    check("pc_8", bus.req_pc, 32'h8);
    check("count_2", bus.fetch_count, 32'd2);

    // Backpressure via ready, then via stall.
    bus.req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("nrdy_pc", bus.req_pc, 32'h8);
      check("nrdy_count", bus.fetch_count, 32'd2);
    end
    bus.req_ready = 1'b1;
    bus.stall     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", bus.req_pc, 32'h8);
      check("stall_count", bus.fetch_count, 32'd2);
    end
    bus.stall = 1'b0;
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    exp_q.push_back(32'h10);
    tick();
    check("count_3", bus.fetch_count, 32'd3);
    check("pc_c", bus.req_pc, 32'hC);
    tick();
    check("pc_10", bus.req_pc, 32'h10);

    // Redirect coincident with a fire at 0x10.
    redirect(32'h100);
    check("rd_bubble_valid", 32'(bus.req_valid), 32'd0);
    check("rd_count", bus.fetch_count, 32'd5);
    exp_q.push_back(32'h100);
    tick();
    check("rd_valid", 32'(bus.req_valid), 32'd1);
    check("rd_pc", bus.req_pc, 32'h100);
    check("rd_pc4", bus.req_pc4, 32'h104);
    tick();
    check("pc_104", bus.req_pc, 32'h104);
    check("count_6", bus.fetch_count, 32'd6);

    // Misaligned redirect parks in ERR until an aligned redirect.
    bus.req_ready = 1'b0;
    redirect(32'h102);
    for (int i = 0; i < 5; i++) begin
      check("err_mis", 32'(bus.misaligned), 32'd1);
      check("err_valid", 32'(bus.req_valid), 32'd0);
      tick();
    end
    redirect(32'h200);
    check("err_clr", 32'(bus.misaligned), 32'd0);
    check("err_bubble", 32'(bus.req_valid), 32'd0);
    tick();
    check("err_exit_valid", 32'(bus.req_valid), 32'd1);
    check("err_exit_pc", bus.req_pc, 32'h200);
    check("err_count", bus.fetch_count, 32'd6);

    // PC wrap at the top of the address space.
    redirect(32'hFFFF_FFFC);
    tick();
    check("wrap_pc", bus.req_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", bus.req_pc4, 32'h0);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    bus.req_ready = 1'b1;
    tick();
    check("wrap_next_pc", bus.req_pc, 32'h0);
    check("count_7", bus.fetch_count, 32'd7);
    tick();
    check("count_8", bus.fetch_count, 32'd8);

    // Halt for four cycles at 0x20.
    bus.req_ready = 1'b0;
    redirect(32'h20);
    tick();
    check("pre_halt_pc", bus.req_pc, 32'h20);
    bus.halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.req_ready = 1'b1;
      check("halt_valid", 32'(bus.req_valid), 32'd0);
      check("halt_count", bus.fetch_count, 32'd8);
    end
    bus.halt = 1'b0;
    tick();
    check("unhalt_valid", 32'(bus.req_valid), 32'd1);
    check("unhalt_pc", bus.req_pc, 32'h20);
    exp_q.push_back(32'h20);
    tick();
    check("count_9", bus.fetch_count, 32'd9);

    // Halt raised in the same cycle as a fire: the fire still advances pc.
    bus.halt = 1'b1;
    exp_q.push_back(32'h24);
    tick();
    check("halt_fire_valid", 32'(bus.req_valid), 32'd0);
    check("halt_fire_pc", bus.req_pc, 32'h28);
    check("count_10", bus.fetch_count, 32'd10);

    // Asynchronous reset mid-HALT, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.req_valid), 32'd0);
    check("arst_pc", bus.req_pc, 32'h0);
    check("arst_pc4", bus.req_pc4, 32'h4);
    check("arst_mis", 32'(bus.misaligned), 32'd0);
    check("arst_count", bus.fetch_count, 32'd0);
    tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_next_gen.md
PC_NEXT_GEN -- requirements
Module: pc_next_gen

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, which is the first PC issued after reset.
REQ-002 SHALL have parameter XLEN, default 32, which is the PC width.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port io_req_valid  output  1  high when io_req_pc is a fetch request.
REQ-006 SHALL have port io_req_ready  input  1  high when the fetch stage accepts a request.
REQ-007 SHALL have port io_req_pc  output  XLEN  the requested PC.
REQ-008 SHALL have port io_req_pc4  output  XLEN  io_req_pc+4, fed to the downstream PC+4 pipeline register.
REQ-009 SHALL have port io_stall  input  1  pipeline stall; blocks acceptance.
REQ-010 SHALL have port io_redirect_valid  input  1  branch/jump/trap redirect strobe.
REQ-011 SHALL have port io_redirect_pc  input  XLEN  redirect target.
REQ-012 SHALL have port io_halt  input  1  level request to suspend fetch.
REQ-013 SHALL have port io_misaligned  output  1  sticky flag for a misaligned redirect target.
REQ-014 SHALL have port io_fetch_count  output  32  count of accepted requests.

Function
REQ-015 SHALL implement states BOOT, RUN, BUBBLE, HALT, ERR; io_req_valid SHALL be high only in RUN.
REQ-016 SHALL define fire as io_req_valid & io_req_ready & !io_stall.
REQ-017 SHALL move BOOT->RUN unconditionally on the first clock edge after reset release, so the first request appears 1 cycle after reset release.
REQ-018 On fire with no redirect, SHALL load pc <= pc+4, stay in RUN, and increment io_fetch_count.
REQ-019 While io_req_valid is high and no fire or redirect occurs, SHALL hold io_req_pc stable.
REQ-020 Redirect SHALL take priority over fire, halt and stall; in the same cycle as a fire, the fired request still counts but pc <= io_redirect_pc.
REQ-021 An aligned redirect (io_redirect_pc[1:0]==0) from any state except BOOT SHALL load pc and enter BUBBLE; BUBBLE SHALL hold valid low for exactly one cycle, then go to RUN, or to HALT if io_halt is high.
REQ-022 A misaligned redirect SHALL load pc, set io_misaligned, and enter ERR; ERR SHALL hold valid low and exit only on an aligned redirect, which clears io_misaligned and enters BUBBLE.
REQ-023 A redirect in BOOT SHALL be ignored.
REQ-024 io_halt high in RUN with no redirect SHALL enter HALT after the current cycle; a fire in that same cycle still advances pc.
REQ-025 HALT SHALL return to RUN the cycle after io_halt falls, at the held pc.
REQ-026 io_req_pc4 SHALL be combinational io_req_pc+4 modulo 2^XLEN; 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000 with no flag.
REQ-027 io_fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.

Reset
REQ-028 Reset asserted SHALL immediately set pc=RESET_VECTOR, state=BOOT, io_req_valid=0, io_misaligned=0, io_fetch_count=0, io_req_pc4=RESET_VECTOR+4, regardless of clock.
REQ-029 Reset asserted mid-request SHALL drop the request without counting it.

Structure
REQ-030 A shared package SHALL hold the state enumeration, XLEN default, and INSN_BYTES=4.
REQ-031 The design SHALL be a single module with no sub-modules; the adder is inline.

Verification
REQ-032 Bench SHALL check reset release with io_req_ready=1: valid rises 1 cycle later, pcs issued are 0x0, 0x4, 0x8, and count reaches 3.
REQ-033 Bench SHALL check backpressure: io_req_ready=0 for 3 cycles at pc 0x8 -> pc stays 0x8 and count is unchanged; with io_stall=1 and ready=1, the same holds.
REQ-034 Bench SHALL check a redirect to 0x100 coincident with a fire at 0x10 -> count +1, one bubble cycle, next valid pc is 0x100 and pc4 is 0x104.
REQ-035 Bench SHALL check a redirect to 0x102 -> io_misaligned=1 and valid low indefinitely; a redirect to 0x200 -> flag clears and after one bubble pc is 0x200.
REQ-036 Bench SHALL check a redirect to 0xFFFF_FFFC -> pc4 is 0x0, and the next fired pc is 0x0.
REQ-037 Bench SHALL check io_halt for 4 cycles at pc 0x20 -> valid low and no count change; one cycle after release, valid is high at 0x20; reset asserted mid-HALT -> immediate return to the REQ-028 values.
